// File: rtl/movement_control.sv
// Per-frame sequencer for the movement datapath: walks the bird, then the player,
// through clear/move/draw, and owns the bird's bounce, fall and escape behaviour.
module movement_control #(
   parameter int FRAME_DIV     = 833333,
   parameter int ESCAPE_FRAMES = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       isShot,
   input  logic       enable,
   input  logic       leave,
   input  logic [7:0] XBhold,
   input  logic [6:0] YBhold,
   output logic [3:0] control,
   output logic       PorB,
   output logic       fly,
   output logic       fall,
   output logic       overrun
);
   typedef enum logic [3:0] {
      S_HOLD    = 4'b0000,
      S_PREHOLD = 4'b0100,
      S_CLEAR   = 4'b0001,
      S_RIGHT   = 4'b0010,
      S_LEFT    = 4'b0011,
      S_DRAW    = 4'b0101,
      S_DOWN    = 4'b0110,
      S_UP      = 4'b0111
   } state_t;

   localparam logic [19:0] DIV_LAST = 20'(FRAME_DIV - 1);
   localparam logic [8:0]  ESC_CNT  = 9'(ESCAPE_FRAMES);

   state_t      state_q, state_d;
   logic [19:0] frame_cnt_q, frame_cnt_d;
   logic        tick_pend_q, tick_pend_d;
   logic        overrun_q, overrun_d;
   logic        porb_q, porb_d;
   logic        fly_q, fly_d;
   logic        fall_q, fall_d;
   logic        dx_q, dx_d;
   logic        dy_q, dy_d;
   logic [8:0]  spawn_q, spawn_d;
   // A plan slot holding S_HOLD means "no move on this axis".
   state_t      bird_h_q, bird_h_d, bird_v_q, bird_v_d;
   state_t      player_h_q, player_h_d, player_v_q, player_v_d;
   state_t      cur_h, cur_v;
   logic        tick, in_prehold;

   always_comb begin
      tick        = (frame_cnt_q == DIV_LAST);
      frame_cnt_d = tick ? 20'd0 : frame_cnt_q + 20'd1;
      in_prehold  = (state_q == S_PREHOLD);

      overrun_d   = tick & tick_pend_q;
      tick_pend_d = tick_pend_q;
      if (state_q == S_HOLD && tick_pend_q)
         tick_pend_d = 1'b0;
      if (tick && !tick_pend_q)
         tick_pend_d = 1'b1;

      fall_d  = fall_q | (isShot & ~fly_q);
      fly_d   = fly_q | (in_prehold & (spawn_q == ESC_CNT) & ~fall_d);
      spawn_d = (in_prehold && spawn_q < ESC_CNT) ? spawn_q + 9'd1 : spawn_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      if (in_prehold) begin
         if (XBhold <= 8'd2)
            dx_d = 1'b1;
         else if (XBhold >= 8'd158)
            dx_d = 1'b0;
         if (YBhold == 7'd0)
            dy_d = 1'b1;
         else if (YBhold >= 7'd117)
            dy_d = 1'b0;
      end
      if (leave) begin
         fall_d  = 1'b0;
         fly_d   = 1'b0;
         spawn_d = 9'd0;
         dx_d    = 1'b1;
         dy_d    = 1'b0;
      end

      bird_h_d   = bird_h_q;
      bird_v_d   = bird_v_q;
      player_h_d = player_h_q;
      player_v_d = player_v_q;
      if (in_prehold) begin
         if (fall_d) begin
            bird_h_d = S_HOLD;
            bird_v_d = S_DOWN;
         end else if (fly_d) begin
            bird_h_d = S_HOLD;
            bird_v_d = S_UP;
         end else begin
            bird_h_d = dx_d ? S_RIGHT : S_LEFT;
            bird_v_d = dy_d ? S_DOWN : S_UP;
         end
         player_h_d = (key_left & ~key_right) ? S_LEFT :
                      (key_right & ~key_left) ? S_RIGHT : S_HOLD;
         player_v_d = (key_up & ~key_down) ? S_UP :
                      (key_down & ~key_up) ? S_DOWN : S_HOLD;
      end

      cur_h   = porb_q ? bird_h_q : player_h_q;
      cur_v   = porb_q ? bird_v_q : player_v_q;
      state_d = state_q;
      porb_d  = porb_q;
      case (state_q)
         S_HOLD:    if (tick_pend_q) state_d = S_PREHOLD;
         S_PREHOLD: state_d = S_CLEAR;
         S_CLEAR: begin
            if (enable)
               state_d = (cur_h != S_HOLD) ? cur_h :
                         (cur_v != S_HOLD) ? cur_v : S_DRAW;
         end
         S_LEFT, S_RIGHT: state_d = (cur_v != S_HOLD) ? cur_v : S_DRAW;
         S_UP, S_DOWN:    state_d = S_DRAW;
         S_DRAW: begin
            if (enable) begin
               state_d = porb_q ? S_CLEAR : S_HOLD;
               porb_d  = ~porb_q;
            end
         end
         default: state_d = S_HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_HOLD;
         frame_cnt_q <= 20'd0;
         tick_pend_q <= 1'b0;
         overrun_q   <= 1'b0;
         porb_q      <= 1'b1;
         fly_q       <= 1'b0;
         fall_q      <= 1'b0;
         dx_q        <= 1'b1;
         dy_q        <= 1'b0;
         spawn_q     <= 9'd0;
         bird_h_q    <= S_HOLD;
         bird_v_q    <= S_HOLD;
         player_h_q  <= S_HOLD;
         player_v_q  <= S_HOLD;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         tick_pend_q <= tick_pend_d;
         overrun_q   <= overrun_d;
         porb_q      <= porb_d;
         fly_q       <= fly_d;
         fall_q      <= fall_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         spawn_q     <= spawn_d;
         bird_h_q    <= bird_h_d;
         bird_v_q    <= bird_v_d;
         player_h_q  <= player_h_d;
         player_v_q  <= player_v_d;
      end
   end

   assign control = state_q;
   assign PorB    = porb_q;
   assign fly     = fly_q;
   assign fall    = fall_q;
   assign overrun = overrun_q;
endmodule

// File: tb/tb_movement_control.sv
// Self-checking bench for movement_control: table frames, hand-written corner
// sequences and randomized frames against a frame-level behavioural model.
module tb_movement_control;
   localparam int FD  = 64;
   localparam int ESC = 3;
   localparam logic [3:0] C_HOLD = 4'b0000, C_PRE = 4'b0100, C_CLR = 4'b0001,
                          C_R = 4'b0010, C_L = 4'b0011, C_DRAW = 4'b0101,
                          C_DN = 4'b0110, C_UP = 4'b0111, C_NONE = 4'b0000;

   typedef struct {
      logic [7:0] xb;
      logic [6:0] yb;
      logic [3:0] keys;   // {left, right, up, down}
      logic [3:0] bh, bv, ph, pv;
   } vec_t;

   logic       clk = 1'b0, reset = 1'b1;
   logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
   logic       isShot = 1'b0, enable = 1'b0, leave = 1'b0;
   logic [7:0] XBhold = 8'd80;
   logic [6:0] YBhold = 7'd60;
   logic [3:0] control;
   logic       PorB, fly, fall, overrun;

   movement_control #(.FRAME_DIV(FD), .ESCAPE_FRAMES(ESC)) dut (
      .clk(clk), .reset(reset),
      .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
      .isShot(isShot), .enable(enable), .leave(leave),
      .XBhold(XBhold), .YBhold(YBhold),
      .control(control), .PorB(PorB), .fly(fly), .fall(fall), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk or posedge reset)
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;

   int checks = 0, errors = 0, fnum = 0;
   int t_ticks, ov_cnt;
   bit m_dx = 1'b1, m_dy = 1'b0, m_fall = 1'b0, m_fly = 1'b0;
   int m_spawn = 0;
   logic [3:0] q_code[$];
   bit         q_porb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock of frame time: note a tick in the current cycle, then count overrun.
   task automatic step();
      if (cyc % FD == FD - 1) t_ticks++;
      @(negedge clk);
      if (overrun === 1'b1) ov_cnt++;
   endtask

   task automatic model_reset();
      m_dx = 1'b1; m_dy = 1'b0; m_fall = 1'b0; m_fly = 1'b0; m_spawn = 0;
   endtask

   task automatic model_prehold(output logic [3:0] bh, output logic [3:0] bv,
                                output logic [3:0] ph, output logic [3:0] pv);
      int x, y;
      x = XBhold;
      y = YBhold;
      if (m_spawn == ESC && !m_fall) m_fly = 1'b1;
      if (m_spawn < ESC) m_spawn++;
      if (x <= 2) m_dx = 1'b1;
      if (x >= 158) m_dx = 1'b0;
      if (y == 0) m_dy = 1'b1;
      if (y >= 117) m_dy = 1'b0;
      if (m_fall) begin
         bh = C_NONE; bv = C_DN;
      end else if (m_fly) begin
         bh = C_NONE; bv = C_UP;
      end else begin
         bh = m_dx ? C_R : C_L;
         bv = m_dy ? C_DN : C_UP;
      end
      ph = (key_left == key_right) ? C_NONE : (key_left ? C_L : C_R);
      pv = (key_up == key_down) ? C_NONE : (key_up ? C_UP : C_DN);
   endtask

   task automatic pulse(input bit s, input bit l);
      isShot = s;
      leave  = l;
      @(negedge clk);
      isShot = 1'b0;
      leave  = 1'b0;
      if (l) model_reset();
      else if (s && !m_fly) m_fall = 1'b1;
      chk("pulse_fall", fall, m_fall);
      chk("pulse_fly", fly, m_fly);
   endtask

   task automatic run_frame(input bit use_tab, input vec_t v, input int first_wait,
                            input bit shot_mid);
      int n, w, exp_ov;
      bit first_clear;
      logic [3:0] bh, bv, ph, pv;
      n = 0;
      while (control !== C_PRE && n < 300) begin
         enable = (control === C_HOLD) && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         n++;
      end
      enable = 1'b0;
      fnum++;
      if (n >= 300) begin
         chk($sformatf("f%0d_prehold_timeout", fnum), 0, 1);
         return;
      end
      model_prehold(bh, bv, ph, pv);
      if (use_tab) begin
         bh = v.bh; bv = v.bv; ph = v.ph; pv = v.pv;
      end
      q_code.delete();
      q_porb.delete();
      q_code.push_back(C_PRE); q_porb.push_back(1'b1);
      q_code.push_back(C_CLR); q_porb.push_back(1'b1);
      if (bh != C_NONE) begin q_code.push_back(bh); q_porb.push_back(1'b1); end
      if (bv != C_NONE) begin q_code.push_back(bv); q_porb.push_back(1'b1); end
      q_code.push_back(C_DRAW); q_porb.push_back(1'b1);
      q_code.push_back(C_CLR);  q_porb.push_back(1'b0);
      if (ph != C_NONE) begin q_code.push_back(ph); q_porb.push_back(1'b0); end
      if (pv != C_NONE) begin q_code.push_back(pv); q_porb.push_back(1'b0); end
      q_code.push_back(C_DRAW); q_porb.push_back(1'b0);
      q_code.push_back(C_HOLD); q_porb.push_back(1'b1);
      t_ticks = 0;
      ov_cnt = 0;
      first_clear = 1'b1;
      for (int i = 0; i < q_code.size(); i++) begin
         chk($sformatf("f%0d_code%0d", fnum, i), control, q_code[i]);
         chk($sformatf("f%0d_porb%0d", fnum, i), PorB, q_porb[i]);
         if (i == q_code.size() - 1) break;
         if (q_code[i] == C_CLR || q_code[i] == C_DRAW) begin
            w = (first_clear && first_wait >= 0) ? first_wait : $urandom_range(0, 4);
            if (first_clear && shot_mid && w < 1) w = 1;
            for (int k = 0; k < w; k++) begin
               isShot = first_clear && shot_mid && (k == 0);
               step();
               isShot = 1'b0;
               chk($sformatf("f%0d_stay%0d", fnum, i), control, q_code[i]);
            end
            if (first_clear && shot_mid) begin
               if (!m_fly) m_fall = 1'b1;
               chk($sformatf("f%0d_fall_mid", fnum), fall, m_fall);
            end
            first_clear = 1'b0;
            enable = 1'b1;
            step();
            enable = 1'b0;
         end else begin
            step();
         end
      end
      exp_ov = (t_ticks > 0) ? t_ticks - 1 : 0;
      chk($sformatf("f%0d_overruns", fnum), ov_cnt, exp_ov);
      chk($sformatf("f%0d_fall", fnum), fall, m_fall);
      chk($sformatf("f%0d_fly", fnum), fly, m_fly);
      $display("frame %0d: bird %h/%h player %h/%h fall=%0d fly=%0d overruns=%0d",
               fnum, bh, bv, ph, pv, fall, fly, ov_cnt);
   endtask

   task automatic set_in(input logic [7:0] x, input logic [6:0] y, input logic [3:0] k);
      XBhold = x;
      YBhold = y;
      {key_left, key_right, key_up, key_down} = k;
   endtask

   initial begin
      vec_t tab[6];
      vec_t dummy;
      tab[0] = '{8'd158, 7'd117, 4'b0000, C_L, C_UP, C_NONE, C_NONE};
      tab[1] = '{8'd2,   7'd0,   4'b0000, C_R, C_DN, C_NONE, C_NONE};
      tab[2] = '{8'd158, 7'd0,   4'b1101, C_L, C_DN, C_NONE, C_DN};
      tab[3] = '{8'd2,   7'd117, 4'b1010, C_R, C_UP, C_L,    C_UP};
      tab[4] = '{8'd80,  7'd60,  4'b0101, C_R, C_UP, C_R,    C_DN};
      tab[5] = '{8'd158, 7'd117, 4'b0111, C_L, C_UP, C_R,    C_NONE};
      dummy  = tab[4];

      repeat (3) @(negedge clk);
      chk("rst_control", control, C_HOLD);
      chk("rst_porb", PorB, 1);
      chk("rst_fly", fly, 0);
      chk("rst_fall", fall, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         set_in(tab[i].xb, tab[i].yb, tab[i].keys);
         pulse(1'b0, 1'b1);
         run_frame(1'b1, tab[i], 3, 1'b0);
      end

      // Shot mid-frame, falling frame, then leave and simultaneous shot+leave.
      set_in(8'd80, 7'd60, 4'b0000);
      pulse(1'b0, 1'b1);
      run_frame(1'b0, dummy, 3, 1'b1);
      chk("fall_after_shot", fall, 1);
      run_frame(1'b0, dummy, 3, 1'b0);
      pulse(1'b0, 1'b1);
      chk("fall_cleared_by_leave", fall, 0);
      run_frame(1'b0, dummy, 3, 1'b0);
      pulse(1'b1, 1'b1);
      chk("leave_beats_shot", fall, 0);
      run_frame(1'b0, dummy, 3, 1'b0);

      // Escape after ESC frames; shot ignored while flying.
      pulse(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) run_frame(1'b0, dummy, 3, 1'b0);
      chk("fly_set", fly, 1);
      pulse(1'b1, 1'b0);
      chk("shot_ignored_in_fly", fall, 0);
      run_frame(1'b0, dummy, 3, 1'b0);
      pulse(1'b0, 1'b1);

      // Stall in CLEAR across several frame ticks.
      run_frame(1'b0, dummy, 200, 1'b0);
      run_frame(1'b0, dummy, 3, 1'b0);

      for (int i = 0; i < 25; i++) begin
         int r;
         set_in(8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 4'($urandom));
         r = $urandom_range(0, 9);
         if (r < 2)       pulse(1'b1, 1'b0);
         else if (r < 4)  pulse(1'b0, 1'b1);
         else if (r == 4) pulse(1'b1, 1'b1);
         run_frame(1'b0, dummy, -1, $urandom_range(0, 4) == 0);
      end

      // Reset in the middle of a bird pass.
      begin
         int n;
         n = 0;
         while (control !== C_PRE && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk("midrst_reach_prehold", control, C_PRE);
         repeat (3) @(negedge clk);
         reset = 1'b1;
         #1;
         chk("midrst_control", control, C_HOLD);
         chk("midrst_porb", PorB, 1);
         chk("midrst_fall", fall, 0);
         chk("midrst_fly", fly, 0);
         @(negedge clk);
         reset = 1'b0;
         model_reset();
      end
      set_in(8'd80, 7'd60, 4'b0000);
      run_frame(1'b0, dummy, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
